// File: rtl/alive_wd_pkg.sv
// Shared types for the alive/watchdog link monitor:
// FSM states, fault codes, synchronizer depth, tolerance helper.
package alive_wd_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_NO_SIGNAL = 3'd1,
    FC_TIMEOUT   = 3'd2,
    FC_PERIOD    = 3'd3,
    FC_HIGH      = 3'd4,
    FC_ACK       = 3'd5
  } fault_e;

  function automatic logic out_of_tol(
    input logic [31:0] v,
    input logic [31:0] nom,
    input logic [31:0] tol
  );
    logic [31:0] d;
    d = (v > nom) ? v - nom : nom - v;
    return d > tol;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input
// with single-cycle rise/fall pulses on the synced level.
module sync_edge_detect
  import alive_wd_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/alive_watchdog_monitor.sv
// Partner-board alive/heartbeat supervisor with latched fault codes.
// Optional FAULT_COUNTER_EN adds a saturating fault counter on status[31:16].
module alive_watchdog_monitor
  import alive_wd_pkg::*;
#(
  parameter int unsigned ALIVE_PERIOD_CYCLES = 13750001,
  parameter int unsigned ALIVE_HIGH_CYCLES   = 1250001,
  parameter int unsigned TOL_CYCLES          = 125000,
  parameter int unsigned WD_HALF_CYCLES      = 1250000,
  parameter int unsigned ACK_TIMEOUT_CYCLES  = 64,
  parameter int unsigned CNT_W               = 28
) (
  input  logic        clk,
  input  logic        peripheral_aresetn,
  input  logic [7:0]  cfg,
  input  logic        alive_signal_in,
  input  logic        reset_ack_in,
  output logic        watchdog_out,
  output logic        instant_reset_out,
  output logic        link_ok,
  output logic [31:0] status
);

  localparam int unsigned WD_W = $clog2(WD_HALF_CYCLES + 1);
  localparam int unsigned AK_W = $clog2(ACK_TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(ALIVE_PERIOD_CYCLES + TOL_CYCLES + 1);
  localparam logic [CNT_W-1:0] NS_LIM =
    CNT_W'(2 * ALIVE_PERIOD_CYCLES + TOL_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(WD_HALF_CYCLES - 1);
  localparam logic [AK_W-1:0] AK_LAST =
    AK_W'(ACK_TIMEOUT_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  fault_e           r_code, w_code_nxt, w_fault;
  logic [CNT_W-1:0] r_per_cnt, w_per_nxt;
  logic [WD_W-1:0]  r_wd_cnt, w_wd_cnt_nxt;
  logic [AK_W-1:0]  r_ack_cnt, w_ack_cnt_nxt;
  logic             r_wd, w_wd_nxt;
  logic             r_ack_pend, w_pend_nxt;
  logic             r_clr_d;

  logic w_alive_s, w_alive_rise, w_alive_fall;
  logic w_ack_s, w_unused_ack_r, w_unused_ack_f;
  logic w_en, w_clr_rise, w_active, w_toggle;
  logic w_ack_bad, w_fault_entry;
  logic [15:0] w_fcnt;
  logic w_unused_cfg;

  sync_edge_detect u_alive_sync (
    .i_clk   (clk),
    .i_rst_n (peripheral_aresetn),
    .i_d     (alive_signal_in),
    .o_q     (w_alive_s),
    .o_rise  (w_alive_rise),
    .o_fall  (w_alive_fall)
  );

  sync_edge_detect u_ack_sync (
    .i_clk   (clk),
    .i_rst_n (peripheral_aresetn),
    .i_d     (reset_ack_in),
    .o_q     (w_ack_s),
    .o_rise  (w_unused_ack_r),
    .o_fall  (w_unused_ack_f)
  );

  assign w_unused_cfg = ^cfg[7:3];
  assign w_en         = cfg[0];
  assign w_clr_rise   = cfg[1] & ~r_clr_d;
  assign w_active     = (r_state == ST_ACQUIRE) ||
                        (r_state == ST_LOCKED);
  assign w_toggle     = w_active && (r_wd_cnt == WD_LAST);
  assign w_ack_bad    = cfg[2] && r_ack_pend &&
                        (w_ack_s != r_wd) &&
                        (r_ack_cnt >= AK_LAST);

  // Lowest code wins when several checks trip together.
  always_comb begin
    w_fault = FC_NONE;
    if (r_state == ST_ACQUIRE) begin
      if (!w_alive_rise && r_per_cnt >= NS_LIM)
        w_fault = FC_NO_SIGNAL;
      else if (w_ack_bad)
        w_fault = FC_ACK;
    end else if (r_state == ST_LOCKED) begin
      if (!w_alive_rise && r_per_cnt >= TO_LIM)
        w_fault = FC_TIMEOUT;
      else if (w_alive_rise &&
               out_of_tol(32'(r_per_cnt),
                          ALIVE_PERIOD_CYCLES,
                          TOL_CYCLES))
        w_fault = FC_PERIOD;
      else if (w_alive_fall &&
               out_of_tol(32'(r_per_cnt),
                          ALIVE_HIGH_CYCLES,
                          TOL_CYCLES))
        w_fault = FC_HIGH;
      else if (w_ack_bad)
        w_fault = FC_ACK;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_per_nxt     = r_per_cnt;
    w_wd_cnt_nxt  = r_wd_cnt;
    w_wd_nxt      = r_wd;
    w_ack_cnt_nxt = r_ack_cnt;
    w_pend_nxt    = r_ack_pend;

    if (w_active) begin
      if (w_alive_rise)
        w_per_nxt = CNT_W'(1);
      else if (!(&r_per_cnt))
        w_per_nxt = r_per_cnt + 1'b1;

      if (r_ack_pend) begin
        if (w_ack_s == r_wd)
          w_pend_nxt = 1'b0;
        else if (r_ack_cnt != AK_LAST)
          w_ack_cnt_nxt = r_ack_cnt + 1'b1;
      end

      if (w_toggle) begin
        w_wd_cnt_nxt  = '0;
        w_wd_nxt      = ~r_wd;
        w_pend_nxt    = 1'b1;
        w_ack_cnt_nxt = '0;
      end else begin
        w_wd_cnt_nxt  = r_wd_cnt + 1'b1;
      end
    end

    unique case (r_state)
      ST_DISABLED: begin
        if (w_en) begin
          w_state_nxt  = ST_ACQUIRE;
          w_per_nxt    = '0;
          w_wd_cnt_nxt = '0;
        end
      end
      ST_ACQUIRE: begin
        if (w_fault != FC_NONE) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = w_fault;
        end else if (w_alive_rise) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_fault != FC_NONE) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = w_fault;
        end
      end
      ST_FAULT: begin
        if (w_clr_rise) begin
          w_state_nxt   = ST_ACQUIRE;
          w_code_nxt    = FC_NONE;
          w_per_nxt     = '0;
          w_wd_cnt_nxt  = '0;
          w_ack_cnt_nxt = '0;
          w_pend_nxt    = 1'b0;
        end
      end
    endcase

    if (!w_en) begin
      w_state_nxt   = ST_DISABLED;
      w_code_nxt    = FC_NONE;
      w_per_nxt     = '0;
      w_wd_cnt_nxt  = '0;
      w_wd_nxt      = 1'b0;
      w_ack_cnt_nxt = '0;
      w_pend_nxt    = 1'b0;
    end
  end

  assign w_fault_entry = (w_state_nxt == ST_FAULT) &&
                         (r_state != ST_FAULT);

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      r_state    <= ST_DISABLED;
      r_code     <= FC_NONE;
      r_per_cnt  <= '0;
      r_wd_cnt   <= '0;
      r_wd       <= 1'b0;
      r_ack_cnt  <= '0;
      r_ack_pend <= 1'b0;
      r_clr_d    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_per_cnt  <= w_per_nxt;
      r_wd_cnt   <= w_wd_cnt_nxt;
      r_wd       <= w_wd_nxt;
      r_ack_cnt  <= w_ack_cnt_nxt;
      r_ack_pend <= w_pend_nxt;
      r_clr_d    <= cfg[1];
    end
  end

`ifdef FAULT_COUNTER_EN
  logic [15:0] r_fcnt;

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn)
      r_fcnt <= '0;
    else if (w_fault_entry && !(&r_fcnt))
      r_fcnt <= r_fcnt + 1'b1;
  end

  assign w_fcnt = r_fcnt;
`else
  logic w_unused_entry;
  assign w_unused_entry = w_fault_entry;
  assign w_fcnt         = 16'h0000;
`endif

  assign watchdog_out      = r_wd;
  assign instant_reset_out = (r_state == ST_FAULT);
  assign link_ok           = (r_state == ST_LOCKED);
  assign status = {w_fcnt, 8'h00, r_wd, w_ack_s,
                   w_alive_s, r_code, r_state};

endmodule

// File: tb/tb_alive_watchdog_monitor.sv
// Directed bench for alive_watchdog_monitor with scaled-down
// timing (period 110, high 10, tol 2, wd half 20, ack timeout 4).
module tb_alive_watchdog_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg = 8'h00;
  logic        alive = 1'b0;
  logic        ack_loop = 1'b0;
  logic        wd;
  logic        inst;
  logic        lnk;
  logic [31:0] status;
  wire         ack_in = ack_loop ? wd : 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alive_watchdog_monitor #(
    .ALIVE_PERIOD_CYCLES (110),
    .ALIVE_HIGH_CYCLES   (10),
    .TOL_CYCLES          (2),
    .WD_HALF_CYCLES      (20),
    .ACK_TIMEOUT_CYCLES  (4),
    .CNT_W               (28)
  ) dut (
    .clk                (clk),
    .peripheral_aresetn (rst_n),
    .cfg                (cfg),
    .alive_signal_in    (alive),
    .reset_ack_in       (ack_in),
    .watchdog_out       (wd),
    .instant_reset_out  (inst),
    .link_ok            (lnk),
    .status             (status)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alive = 1'b0;
    cfg   = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Rise driven at edge k; returns at k+110 with alive low.
  task automatic start_lock(input logic [7:0] c);
    do_reset();
    ack_loop = 1'b1;
    cfg = c;
    tick(1);
    alive = 1'b1;
    tick(10);
    alive = 1'b0;
    tick(100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg = 8'h00;
    alive = 1'b0;
    tick(2);
    total++;
    if (status !== 32'h0) begin
      bad++;
      $display("FAIL rst_status got=%h exp=%h", status, 32'h0);
    end
    total++;
    if ({wd, inst, lnk} !== 3'b000) begin
      bad++;
      $display("FAIL rst_outs got=%b exp=000", {wd, inst, lnk});
    end
    rst_n = 1'b1;
    tick(3);
    total++;
    if (status !== 32'h0) begin
      bad++;
      $display("FAIL idle_status got=%h exp=%h", status, 32'h0);
    end
  endtask

  task automatic test_lock();
    do_reset();
    ack_loop = 1'b1;
    cfg = 8'h05;
    tick(1);
    total++;
    if (status[1:0] !== 2'd1) begin
      bad++;
      $display("FAIL acq_state got=%0d exp=1", status[1:0]);
    end
    tick(19);
    total++;
    if (wd !== 1'b0) begin
      bad++;
      $display("FAIL wd_pre got=%b exp=0", wd);
    end
    tick(1);
    total++;
    if (wd !== 1'b1) begin
      bad++;
      $display("FAIL wd_first got=%b exp=1", wd);
    end
    alive = 1'b1;
    tick(2);
    total++;
    if (lnk !== 1'b0) begin
      bad++;
      $display("FAIL lock_early got=%b exp=0", lnk);
    end
    tick(1);
    total++;
    if (lnk !== 1'b1) begin
      bad++;
      $display("FAIL lock got=%b exp=1", lnk);
    end
    tick(7);
    alive = 1'b0;
    tick(100);
    for (int i = 0; i < 10; i++) begin
      alive = 1'b1;
      tick(10);
      alive = 1'b0;
      tick(100);
      total++;
      if (inst !== 1'b0 || lnk !== 1'b1) begin
        bad++;
        $display("FAIL period_ok[%0d] inst=%b lnk=%b exp 0/1",
                 i, inst, lnk);
      end
    end
    total++;
    if (status[4:2] !== 3'd0) begin
      bad++;
      $display("FAIL lock_code got=%0d exp=0", status[4:2]);
    end
  endtask

  // Registered rise at k+3, per_cnt hits 113 at k+115.
  task automatic test_timeout();
    start_lock(8'h05);
    tick(5);
    total++;
    if (inst !== 1'b0) begin
      bad++;
      $display("FAIL to_early got=%b exp=0", inst);
    end
    tick(1);
    total++;
    if (inst !== 1'b1 || status[4:2] !== 3'd2) begin
      bad++;
      $display("FAIL timeout inst=%b code=%0d exp 1/2",
               inst, status[4:2]);
    end
  endtask

  task automatic test_period();
    start_lock(8'h05);
    tick(2);
    alive = 1'b1;
    tick(10);
    alive = 1'b0;
    tick(103);
    alive = 1'b1;
    tick(2);
    total++;
    if (inst !== 1'b0 || lnk !== 1'b1) begin
      bad++;
      $display("FAIL per112 inst=%b lnk=%b exp 0/1", inst, lnk);
    end
    tick(1);
    total++;
    if (inst !== 1'b1 || status[4:2] !== 3'd3) begin
      bad++;
      $display("FAIL per113 inst=%b code=%0d exp 1/3",
               inst, status[4:2]);
    end
  endtask

  task automatic test_high();
    start_lock(8'h05);
    alive = 1'b1;
    tick(12);
    alive = 1'b0;
    tick(98);
    alive = 1'b1;
    tick(13);
    alive = 1'b0;
    tick(2);
    total++;
    if (inst !== 1'b0 || lnk !== 1'b1) begin
      bad++;
      $display("FAIL hi12 inst=%b lnk=%b exp 0/1", inst, lnk);
    end
    tick(1);
    total++;
    if (inst !== 1'b1 || status[4:2] !== 3'd4) begin
      bad++;
      $display("FAIL hi13 inst=%b code=%0d exp 1/4",
               inst, status[4:2]);
    end
  endtask

  task automatic test_ack();
    do_reset();
    ack_loop = 1'b0;
    cfg = 8'h05;
    tick(24);
    total++;
    if (inst !== 1'b0 || wd !== 1'b1) begin
      bad++;
      $display("FAIL ack_early inst=%b wd=%b exp 0/1", inst, wd);
    end
    tick(1);
    total++;
    if (inst !== 1'b1 || status[4:2] !== 3'd5) begin
      bad++;
      $display("FAIL ack inst=%b code=%0d exp 1/5",
               inst, status[4:2]);
    end
    do_reset();
    cfg = 8'h01;
    tick(100);
    total++;
    if (inst !== 1'b0 || status[1:0] !== 2'd1) begin
      bad++;
      $display("FAIL ack_off inst=%b st=%0d exp 0/1",
               inst, status[1:0]);
    end
    tick(122);
    total++;
    if (inst !== 1'b0) begin
      bad++;
      $display("FAIL nosig_early got=%b exp=0", inst);
    end
    tick(1);
    total++;
    if (inst !== 1'b1 || status[4:2] !== 3'd1) begin
      bad++;
      $display("FAIL nosig inst=%b code=%0d exp 1/1",
               inst, status[4:2]);
    end
  endtask

  // Continues from the NO_SIGNAL fault; wd froze at 1.
  task automatic test_recovery();
    tick(30);
    total++;
    if (wd !== 1'b1 || inst !== 1'b1 || status[4:2] !== 3'd1) begin
      bad++;
      $display("FAIL frozen wd=%b inst=%b code=%0d exp 1/1/1",
               wd, inst, status[4:2]);
    end
    cfg = 8'h03;
    tick(1);
    total++;
    if (status[1:0] !== 2'd1 || status[4:2] !== 3'd0 ||
        inst !== 1'b0) begin
      bad++;
      $display("FAIL clear st=%0d code=%0d inst=%b exp 1/0/0",
               status[1:0], status[4:2], inst);
    end
    cfg = 8'h01;
    do_reset();
    ack_loop = 1'b0;
    cfg = 8'h05;
    tick(25);
    cfg = 8'h04;
    tick(1);
    total++;
    if (status[4:0] !== 5'd0 || inst !== 1'b0 || wd !== 1'b0) begin
      bad++;
      $display("FAIL disable st=%h inst=%b wd=%b exp 0/0/0",
               status[4:0], inst, wd);
    end
    do_reset();
    cfg = 8'h05;
    tick(25);
    total++;
    if (inst !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got=%b exp=1", inst);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({wd, inst, lnk} !== 3'b000 || status !== 32'h0) begin
      bad++;
      $display("FAIL rst_fault outs=%b status=%h exp 000/0",
               {wd, inst, lnk}, status);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_fault_count();
    logic [15:0] exp_cnt;
`ifdef FAULT_COUNTER_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    ack_loop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg = 8'h05;
      tick(25);
      total++;
      if (inst !== 1'b1) begin
        bad++;
        $display("FAIL cnt_fault[%0d] got=%b exp=1", i, inst);
      end
      cfg = 8'h04;
      tick(1);
    end
    total++;
    if (status[31:16] !== exp_cnt) begin
      bad++;
      $display("FAIL fault_count got=%0d exp=%0d",
               status[31:16], exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_timeout();
    test_period();
    test_high();
    test_ack();
    test_recovery();
    test_fault_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
